// File: rtl/mdu_pkg.sv
// Shared opcode and FSM state encodings for the iterative multiply/divide unit.
// The DIV state exists only when MDU_DIV_EN is defined.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mduOp_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
`ifdef MDU_DIV_EN
    ST_DIV   = 2'd2,
`endif
    ST_FIXUP = 2'd3
  } mduState_t;

endpackage

// File: rtl/mdu_cneg.sv
// Conditional two's-complement: res = neg ? -val : val.
module mdu_cneg #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// Optional divider: define MDU_DIV_EN; otherwise DIV/DIVU pulse illegal_o.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             rd_req_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o,
  output logic             illegal_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mduState_t            stateReg, stateNext;
  logic [CNT_W-1:0]     cntReg, cntNext;
  logic [2*WIDTH-1:0]   accReg, accNext;
  logic [WIDTH-1:0]     opndReg, opndNext;
  logic [WIDTH-1:0]     hiReg, hiNext, loReg, loNext;
  logic                 doneReg, doneNext;
  logic                 resSignReg, resSignNext;
`ifdef MDU_DIV_EN
  logic                 remSignReg, remSignNext;
  logic                 isDivReg, isDivNext;
`else
  logic                 illegalReg, illegalNext;
`endif

  // Operand magnitudes: signed ops take |x|, unsigned ops pass through.
  logic                 signedOp;
  logic [WIDTH-1:0]     opRaw [2];
  logic [WIDTH-1:0]     opMag [2];
  logic                 opNeg [2];

  assign signedOp = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign opRaw[0] = a_i;
  assign opRaw[1] = b_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gOperand
      assign opNeg[gi] = signedOp && opRaw[gi][WIDTH-1];
      mdu_cneg #(.W(WIDTH)) uMag (
        .val (opRaw[gi]),
        .neg (opNeg[gi]),
        .res (opMag[gi])
      );
    end
  endgenerate

  // Shift-add step: accReg = {partial product, remaining multiplier bits}.
  logic [WIDTH:0]       mulSum;
  logic [2*WIDTH-1:0]   mulStep;
  logic [2*WIDTH-1:0]   prodFix;

  assign mulSum  = {1'b0, accReg[2*WIDTH-1:WIDTH]}
                 + ({1'b0, opndReg} & {(WIDTH+1){accReg[0]}});
  assign mulStep = {mulSum, accReg[WIDTH-1:1]};

  mdu_cneg #(.W(2*WIDTH)) uProdFix (
    .val (accReg),
    .neg (resSignReg),
    .res (prodFix)
  );

`ifdef MDU_DIV_EN
  // Restoring step: accReg = {partial remainder, dividend bits / quotient bits}.
  logic [WIDTH:0]       divShift;
  logic [WIDTH:0]       divDiff;
  logic [2*WIDTH-1:0]   divStep;
  logic [WIDTH-1:0]     quoFix, remFix;

  assign divShift = {accReg[2*WIDTH-1:WIDTH], accReg[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, opndReg};
  assign divStep  = divDiff[WIDTH]
                  ? {divShift[WIDTH-1:0], accReg[WIDTH-2:0], 1'b0}
                  : {divDiff[WIDTH-1:0],  accReg[WIDTH-2:0], 1'b1};

  mdu_cneg #(.W(WIDTH)) uQuoFix (
    .val (accReg[WIDTH-1:0]),
    .neg (resSignReg),
    .res (quoFix)
  );

  mdu_cneg #(.W(WIDTH)) uRemFix (
    .val (accReg[2*WIDTH-1:WIDTH]),
    .neg (remSignReg),
    .res (remFix)
  );
`endif

  always_comb begin
    stateNext   = stateReg;
    cntNext     = cntReg;
    accNext     = accReg;
    opndNext    = opndReg;
    hiNext      = hiReg;
    loNext      = loReg;
    doneNext    = 1'b0;
    resSignNext = resSignReg;
`ifdef MDU_DIV_EN
    remSignNext = remSignReg;
    isDivNext   = isDivReg;
`else
    illegalNext = 1'b0;
`endif

    case (stateReg)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          case (op_i)
            OP_MULT, OP_MULTU: begin
              stateNext   = ST_MUL;
              cntNext     = CNT_W'(WIDTH);
              accNext     = {{WIDTH{1'b0}}, opMag[1]};
              opndNext    = opMag[0];
              resSignNext = opNeg[0] ^ opNeg[1];
`ifdef MDU_DIV_EN
              isDivNext   = 1'b0;
`endif
            end
            OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV_EN
              stateNext   = ST_DIV;
              cntNext     = CNT_W'(WIDTH);
              accNext     = {{WIDTH{1'b0}}, opMag[0]};
              opndNext    = opMag[1];
              resSignNext = opNeg[0] ^ opNeg[1];
              remSignNext = opNeg[0];
              isDivNext   = 1'b1;
`else
              doneNext    = 1'b1;
              illegalNext = 1'b1;
`endif
            end
            OP_MTHI: begin
              hiNext   = a_i;
              doneNext = 1'b1;
            end
            OP_MTLO: begin
              loNext   = a_i;
              doneNext = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        accNext = mulStep;
        cntNext = cntReg - CNT_W'(1);
        if (cntReg == CNT_W'(1)) stateNext = ST_FIXUP;
      end
`ifdef MDU_DIV_EN
      ST_DIV: begin
        accNext = divStep;
        cntNext = cntReg - CNT_W'(1);
        if (cntReg == CNT_W'(1)) stateNext = ST_FIXUP;
      end
`endif
      ST_FIXUP: begin
        stateNext = ST_IDLE;
        doneNext  = 1'b1;
`ifdef MDU_DIV_EN
        if (isDivReg) begin
          hiNext = remFix;
          loNext = quoFix;
        end else
`endif
        begin
          hiNext = prodFix[2*WIDTH-1:WIDTH];
          loNext = prodFix[WIDTH-1:0];
        end
      end
      default: stateNext = ST_IDLE;
    endcase

    // Abort discards the in-flight result, including one about to commit.
    if (flush_i && stateReg != ST_IDLE) begin
      stateNext = ST_IDLE;
      hiNext    = hiReg;
      loNext    = loReg;
      doneNext  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= ST_IDLE;
      cntReg     <= '0;
      accReg     <= '0;
      opndReg    <= '0;
      hiReg      <= '0;
      loReg      <= '0;
      doneReg    <= 1'b0;
      resSignReg <= 1'b0;
`ifdef MDU_DIV_EN
      remSignReg <= 1'b0;
      isDivReg   <= 1'b0;
`else
      illegalReg <= 1'b0;
`endif
    end else begin
      stateReg   <= stateNext;
      cntReg     <= cntNext;
      accReg     <= accNext;
      opndReg    <= opndNext;
      hiReg      <= hiNext;
      loReg      <= loNext;
      doneReg    <= doneNext;
      resSignReg <= resSignNext;
`ifdef MDU_DIV_EN
      remSignReg <= remSignNext;
      isDivReg   <= isDivNext;
`else
      illegalReg <= illegalNext;
`endif
    end
  end

  assign busy_o  = (stateReg != ST_IDLE);
  assign done_o  = doneReg;
  assign stall_o = busy_o && (start_i || rd_req_i);
  assign hi_o    = hiReg;
  assign lo_o    = loReg;
`ifdef MDU_DIV_EN
  assign illegal_o = 1'b0;
`else
  assign illegal_o = illegalReg;
`endif

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: latency/result model plus directed vectors.
`timescale 1ns/1ps
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         startI = 1'b0;
  logic         flushI = 1'b0;
  logic         rdReqI = 1'b0;
  logic [2:0]   opI = 3'd0;
  logic [W-1:0] aI = '0;
  logic [W-1:0] bI = '0;
  logic         busyO, doneO, stallO, illegalO;
  logic [W-1:0] hiO, loO;

  int tests = 0;
  int fails = 0;

  mdu_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (startI),
    .op_i      (opI),
    .a_i       (aI),
    .b_i       (bI),
    .flush_i   (flushI),
    .rd_req_i  (rdReqI),
    .busy_o    (busyO),
    .done_o    (doneO),
    .stall_o   (stallO),
    .illegal_o (illegalO),
    .hi_o      (hiO),
    .lo_o      (loO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural result of one operation as {HI, LO}, from plain arithmetic.
  function automatic logic [63:0] refResult(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    res = '0;
    case (op)
      OP_MULT:  res = 64'(sa * sb);
      OP_MULTU: res = 64'(ua * ub);
      OP_DIV: begin
        if (b == 0) res = {a, (a[W-1] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Model: an accepted MULT/DIV keeps the unit busy W+1 cycles, then commits.
  int          busyLeft;
  logic [63:0] pend;
  logic [W-1:0] mHi, mLo;
  logic        mDone, mIll;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busyLeft <= 0;
      pend     <= '0;
      mHi      <= '0;
      mLo      <= '0;
      mDone    <= 1'b0;
      mIll     <= 1'b0;
    end else begin
      mDone <= 1'b0;
      mIll  <= 1'b0;
      if (busyLeft > 0) begin
        if (flushI) busyLeft <= 0;
        else begin
          busyLeft <= busyLeft - 1;
          if (busyLeft == 1) begin
            mHi   <= pend[63:32];
            mLo   <= pend[31:0];
            mDone <= 1'b1;
          end
        end
      end else if (startI && !flushI) begin
        case (opI)
          OP_MULT, OP_MULTU: begin
            pend     <= refResult(opI, aI, bI);
            busyLeft <= W + 1;
          end
          OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV_EN
            pend     <= refResult(opI, aI, bI);
            busyLeft <= W + 1;
`else
            mDone <= 1'b1;
            mIll  <= 1'b1;
`endif
          end
          OP_MTHI: begin
            mHi   <= aI;
            mDone <= 1'b1;
          end
          OP_MTLO: begin
            mLo   <= aI;
            mDone <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_busy",    busyO,    busyLeft > 0);
      check("cyc_done",    doneO,    mDone);
      check("cyc_illegal", illegalO, mIll);
      check("cyc_stall",   stallO,   (busyLeft > 0) && (startI || rdReqI));
      check("cyc_hi",      hiO,      mHi);
      check("cyc_lo",      loO,      mLo);
    end
  end

  task automatic runOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int maxWait, output int lat, output logic ill);
    opI = op;
    aI = a;
    bI = b;
    startI = 1'b1;
    lat = -1;
    ill = 1'b0;
    for (int n = 1; n <= maxWait; n++) begin
      @(posedge clk);
      #1;
      startI = 1'b0;
      if (doneO) begin
        lat = n;
        ill = illegalO;
        break;
      end
    end
    $display("[TB] op=%0d a=%h b=%h lat=%0d hi=%h lo=%h ill=%b", op, a, b, lat, hiO, loO, ill);
  endtask

  localparam logic [2:0]   MOP [4] = '{OP_MULT, OP_MULTU, OP_MULT, OP_MULTU};
  localparam logic [W-1:0] MA  [4] = '{32'h8000_0000, 32'h1234_5678, 32'h0000_0007, 32'h0000_0000};
  localparam logic [W-1:0] MB  [4] = '{32'h8000_0000, 32'h0000_0010, 32'hFFFF_FFF7, 32'h0000_0005};
  localparam logic [63:0]  MX  [4] = '{64'h4000_0000_0000_0000, 64'h0000_0001_2345_6780,
                                       64'hFFFF_FFFF_FFFF_FFC1, 64'h0};
`ifdef MDU_DIV_EN
  localparam logic [2:0]   DOP [6] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU, OP_DIV};
  localparam logic [W-1:0] DA  [6] = '{32'hFFFF_FFF9, 32'd10, 32'h8000_0000, 32'hFFFF_FFF8, 32'd100, 32'd7};
  localparam logic [W-1:0] DB  [6] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd7, 32'hFFFF_FFFE};
  localparam logic [63:0]  DX  [6] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_000A_FFFF_FFFF,
                                       64'h0000_0000_8000_0000, 64'hFFFF_FFF8_0000_0001,
                                       64'h0000_0002_0000_000E, 64'h0000_0001_FFFF_FFFD};
`endif

  initial begin
    int   lat;
    int   cnt;
    logic ill;

    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", hiO, 0);
    check("rst_lo", loO, 0);
    check("rst_busy", busyO, 0);
    check("rst_done", doneO, 0);
    check("rst_illegal", illegalO, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    runOp(OP_MTHI, 32'h1234, 32'h0, 5, lat, ill);
    check("mthi_lat", lat, 1);
    check("mthi_hi", hiO, 32'h1234);
    runOp(OP_MTLO, 32'h5678, 32'h0, 5, lat, ill);
    check("mtlo_lo", loO, 32'h5678);
    check("mtlo_hi_kept", hiO, 32'h1234);

    runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 100, lat, ill);
    check("multu_lat", lat, W + 2);
    check("multu_hi", hiO, 32'hFFFF_FFFE);
    check("multu_lo", loO, 32'h0000_0001);
    runOp(OP_MULT, 32'hFFFF_FFFD, 32'd5, 100, lat, ill);
    check("mult_hi", hiO, 32'hFFFF_FFFF);
    check("mult_lo", loO, 32'hFFFF_FFF1);
    for (int i = 0; i < 4; i++) begin
      runOp(MOP[i], MA[i], MB[i], 100, lat, ill);
      check("mul_vec_lat", lat, W + 2);
      check("mul_vec", {hiO, loO}, MX[i]);
    end

    // Flush mid-multiply keeps the MTHI/MTLO values and produces no done.
    runOp(OP_MTHI, 32'h1234, 32'h0, 5, lat, ill);
    runOp(OP_MTLO, 32'h5678, 32'h0, 5, lat, ill);
    opI = OP_MULTU; aI = 32'd2; bI = 32'd3; startI = 1'b1;
    @(posedge clk);
    #1;
    startI = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_flush_busy", busyO, 1);
    flushI = 1'b1;
    @(posedge clk);
    #1;
    flushI = 1'b0;
    check("flush_busy", busyO, 0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_hi", hiO, 32'h1234);
    check("flush_lo", loO, 32'h5678);
    $display("[TB] flush MULTU 2x3 at cycle 10: hi=%h lo=%h", hiO, loO);

    // Held read request and back-to-back start while busy.
    rdReqI = 1'b1;
    opI = OP_MULTU; aI = 32'd6; bI = 32'd7; startI = 1'b1;
    @(posedge clk);
    #1;
    opI = OP_MULT; aI = 32'hFFFF_FFFE; bI = 32'd3;
    check("busy_stall", stallO, 1);
    cnt = 0;
    while (!doneO && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("first_lat", cnt, W + 1);
    check("first_hi", hiO, 0);
    check("first_lo", loO, 42);
    @(posedge clk);
    #1;
    startI = 1'b0;
    rdReqI = 1'b0;
    check("second_accepted", busyO, 1);
    cnt = 0;
    while (!doneO && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("second_hi", hiO, 32'hFFFF_FFFF);
    check("second_lo", loO, 32'hFFFF_FFFA);
    $display("[TB] stalled MULT -2x3 accepted after MULTU 6x7: hi=%h lo=%h", hiO, loO);

    // Asynchronous reset mid-operation.
    opI = OP_MULTU; aI = 32'd5; bI = 32'd5; startI = 1'b1;
    @(posedge clk);
    #1;
    startI = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_hi", hiO, 0);
    check("arst_lo", loO, 0);
    check("arst_busy", busyO, 0);
    check("arst_done", doneO, 0);
    check("arst_stall", stallO, 0);
    $display("[TB] reset mid-MULTU: busy=%b hi=%h lo=%h", busyO, hiO, loO);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef MDU_DIV_EN
    for (int i = 0; i < 6; i++) begin
      runOp(DOP[i], DA[i], DB[i], 100, lat, ill);
      check("div_vec_lat", lat, W + 2);
      check("div_vec", {hiO, loO}, DX[i]);
    end
`else
    runOp(OP_MTHI, 32'hAAAA, 32'h0, 5, lat, ill);
    runOp(OP_MTLO, 32'h5555, 32'h0, 5, lat, ill);
    runOp(OP_DIVU, 32'd9, 32'd3, 5, lat, ill);
    check("nodiv_lat", lat, 1);
    check("nodiv_illegal", ill, 1);
    check("nodiv_hi", hiO, 32'hAAAA);
    check("nodiv_lo", loO, 32'h5555);
`endif

    runOp(3'd6, 32'd1, 32'd1, 4, lat, ill);
    check("unused_op_no_done", lat, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
